// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480@60 VGA timing that scans a 4x-scaled 160x120 3-bit framebuffer
// through a 1-cycle-latency read port and emits a once-per-frame tick.
module vga_scan_reader #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int XRES        = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [2:0]  mem_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_END  = 10'(H_VIS);
    localparam logic [9:0] V_END  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic        phase, pix_en, visible, h_wrap, v_wrap;
    logic        hs1, vs1, vis1;
    logic [9:0]  h, v;
    logic [14:0] row, addr_next;

    assign pix_en     = phase;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;
    assign h_wrap     = h == H_LAST;
    assign v_wrap     = v == V_LAST;
    assign visible    = (h < H_END) && (v < V_END);
    // constant multiply by XRES reduces to (row<<7)+(row<<5) for a 160-wide buffer
    assign row        = 15'(v >> SCALE_SHIFT);
    assign addr_next  = 15'(row * XRES) + 15'(h >> SCALE_SHIFT);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            phase <= 1'b0;
            h     <= '0;
            v     <= '0;
        end else begin
            phase <= ~phase;
            if (pix_en) begin
                h <= h_wrap ? '0 : h + 10'd1;
                if (h_wrap) v <= v_wrap ? '0 : v + 10'd1;
            end
        end
    end

    // stage 1: issue the read and register timing that must line up with the returned data
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            vis1     <= 1'b0;
        end else if (pix_en) begin
            if (visible) mem_addr <= addr_next;
            mem_rd <= visible;
            hs1    <= !((h >= HS_BEG) && (h < HS_END));
            vs1    <= !((v >= VS_BEG) && (v < VS_END));
            vis1   <= visible;
        end
    end

    // stage 2: drive pins; colour is forced to black whenever no read was issued
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (pix_en) begin
            VGA_R       <= vis1 ? {8{mem_data[2]}} : 8'h00;
            VGA_G       <= vis1 ? {8{mem_data[1]}} : 8'h00;
            VGA_B       <= vis1 ? {8{mem_data[0]}} : 8'h00;
            VGA_HS      <= hs1;
            VGA_VS      <= vs1;
            VGA_BLANK_N <= vis1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) frame_start <= 1'b0;
        else       frame_start <= pix_en && h_wrap && v_wrap;
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader: checks the scanner in a shrunken timing configuration against an
// arithmetic model of position-versus-clock, plus vector tables for addressing and colour.
module tb_vga_scan_reader;
    localparam int H_VIS = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int XRES = 8, SCALE_SHIFT = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FR    = H_TOT * V_TOT;
    localparam int FB_N  = XRES * (V_VIS >> SCALE_SHIFT);
    localparam logic [45:0] RST_BUS = {15'd0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic        Clock, Reset;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [2:0]  mem_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;
    logic [45:0] bus;

    vga_scan_reader #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XRES(XRES), .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK), .frame_start(frame_start)
    );

    assign bus = {mem_addr, mem_rd, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
                  VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start};

    logic [2:0] fb [FB_N];
    int k, checks, passed;
    int hs_f[$], hs_r[$], vs_f[$], vs_r[$], fs_k[$];
    logic p_hs, p_vs;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // synchronous-read framebuffer; garbage whenever no read is requested
    always @(posedge Clock) mem_data <= mem_rd ? fb[mem_addr] : 3'($urandom);

    typedef struct packed { logic [31:0] p; logic [14:0] addr; logic rd; } addr_vec_t;
    typedef struct packed { logic [2:0] c; logic [7:0] r; logic [7:0] g; logic [7:0] b; } col_vec_t;
    addr_vec_t av [11];
    col_vec_t  cv [6];

    function automatic bit vis(input int q);
        int r = q % FR;
        return ((r % H_TOT) < H_VIS) && ((r / H_TOT) < V_VIS);
    endfunction

    function automatic int addr_of(input int q);
        int r = q % FR;
        return ((r / H_TOT) >> SCALE_SHIFT) * XRES + ((r % H_TOT) >> SCALE_SHIFT);
    endfunction

    function automatic int last_vis(input int q);
        int r = q % FR;
        int h = r % H_TOT;
        int v = r / H_TOT;
        if (v >= V_VIS) return q - r + (V_VIS - 1) * H_TOT + H_VIS - 1;
        return (h < H_VIS) ? q : q - h + H_VIS - 1;
    endfunction

    // expected pins after k clock edges since reset release; p = pixel periods elapsed,
    // the read port shows position p-1 and the pins show position p-2
    function automatic logic [45:0] model(input int k_in);
        int p = k_in / 2;
        int q, r, h, v;
        logic [14:0] a = '0;
        logic rd = 1'b0, hs = 1'b1, vs = 1'b1, bn = 1'b0, fs;
        logic [2:0] c = 3'b0;
        fs = (k_in % 2 == 0) && (p > 0) && (p % FR == 0);
        if (p >= 1) begin
            rd = vis(p - 1);
            a  = 15'(addr_of(last_vis(p - 1)));
        end
        if (p >= 2) begin
            q  = p - 2;
            r  = q % FR;
            h  = r % H_TOT;
            v  = r / H_TOT;
            bn = vis(q);
            hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
            vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
            c  = bn ? fb[addr_of(q)] : 3'b0;
        end
        return {a, rd, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, bn, 1'b0, 1'(k_in % 2), fs};
    endfunction

    task automatic chk(input string name, input logic [45:0] got, input logic [45:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s k=%0d: got %h, expected %h", name, k, got, exp);
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge Clock);
            k++;
            @(negedge Clock);
            chk("scan", bus, model(k));
            if (p_hs && !VGA_HS) hs_f.push_back(k);
            if (!p_hs && VGA_HS) hs_r.push_back(k);
            if (p_vs && !VGA_VS) vs_f.push_back(k);
            if (!p_vs && VGA_VS) vs_r.push_back(k);
            if (frame_start) fs_k.push_back(k);
            p_hs = VGA_HS;
            p_vs = VGA_VS;
        end
    endtask

    task automatic do_reset(input int fill);
        Reset = 1'b1;
        for (int i = 0; i < FB_N; i++) fb[i] = (fill < 0) ? 3'($urandom) : 3'(fill);
        repeat (2) @(negedge Clock);
        chk("in_reset", bus, RST_BUS);
        Reset = 1'b0;
        k = 0;
        p_hs = 1'b1;
        p_vs = 1'b1;
        hs_f.delete(); hs_r.delete(); vs_f.delete(); vs_r.delete(); fs_k.delete();
        chk("release", bus, model(0));
    endtask

    initial begin
        checks = 0;
        passed = 0;
        k = 0;
        Reset = 1'b1;
        av = '{{32'd1, 15'd0, 1'b1}, {32'd4, 15'd0, 1'b1}, {32'd5, 15'd1, 1'b1},
               {32'd8, 15'd1, 1'b1}, {32'd9, 15'd2, 1'b1}, {32'd32, 15'd7, 1'b1},
               {32'd33, 15'd7, 1'b0}, {32'd48, 15'd7, 1'b0}, {32'd193, 15'd8, 1'b1},
               {32'd1136, 15'd47, 1'b1}, {32'd1153, 15'd47, 1'b0}};
        cv = '{{3'b100, 8'hFF, 8'h00, 8'h00}, {3'b011, 8'h00, 8'hFF, 8'hFF},
               {3'b000, 8'h00, 8'h00, 8'h00}, {3'b111, 8'hFF, 8'hFF, 8'hFF},
               {3'b010, 8'h00, 8'hFF, 8'h00}, {3'b101, 8'hFF, 8'h00, 8'hFF}};
        repeat (3) @(negedge Clock);

        foreach (cv[i]) begin
            do_reset(int'(cv[i].c));
            run_to(4);
            chk("colour_vis", 46'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}),
                46'({1'b1, cv[i].r, cv[i].g, cv[i].b}));
            run_to(2 * (H_VIS + 2));
            chk("colour_blank", 46'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 46'd0);
        end

        do_reset(-1);
        foreach (av[i]) begin
            run_to(2 * int'(av[i].p));
            chk("addr", 46'({mem_addr, mem_rd}), 46'({av[i].addr, av[i].rd}));
        end

        do_reset(-1);
        run_to(2 * (12 * H_TOT + 10));
        #2 Reset = 1'b1;
        #1 chk("async_reset", bus, RST_BUS);
        do_reset(-1);
        run_to(2);
        chk("restart_addr", 46'({mem_addr, mem_rd}), 46'({15'd0, 1'b1}));
        run_to(4 * FR + 250);

        chk("hs_first_fall", 46'(hs_f.size() > 0 ? hs_f[0] : -1), 46'(2 * (H_VIS + H_FP + 2)));
        chk("hs_width", 46'(hs_f.size() > 0 && hs_r.size() > 0 ? hs_r[0] - hs_f[0] : -1),
            46'(2 * H_SYNC));
        chk("hs_period", 46'(hs_f.size() > 1 ? hs_f[1] - hs_f[0] : -1), 46'(2 * H_TOT));
        chk("vs_first_fall", 46'(vs_f.size() > 0 ? vs_f[0] : -1),
            46'(2 * ((V_VIS + V_FP) * H_TOT + 2)));
        chk("vs_width", 46'(vs_f.size() > 0 && vs_r.size() > 0 ? vs_r[0] - vs_f[0] : -1),
            46'(2 * V_SYNC * H_TOT));
        chk("vs_period", 46'(vs_f.size() > 1 ? vs_f[1] - vs_f[0] : -1), 46'(2 * FR));
        chk("fs_count", 46'(fs_k.size()), 46'd2);
        chk("fs_first", 46'(fs_k.size() > 0 ? fs_k[0] : -1), 46'(2 * FR));
        chk("fs_period", 46'(fs_k.size() > 1 ? fs_k[1] - fs_k[0] : -1), 46'(2 * FR));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
